// File: rtl/fan_ctrl_pkg.sv
// Shared types and default thresholds for the fan speed control loop.
package fan_ctrl_pkg;

    localparam int unsigned TEMP_W = 7;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned DEF_T_LOW_ON  = 40;
    localparam int unsigned DEF_T_MED_ON  = 60;
    localparam int unsigned DEF_T_HIGH_ON = 80;
    localparam int unsigned DEF_HYST      = 5;
    localparam int unsigned DEF_T_CRIT    = 100;
    localparam int unsigned DEF_DWELL     = 4;

    typedef enum logic [1:0] {OFF, LOW, MED, HIGH} fan_speed_t;
    typedef enum logic [1:0] {NONE, UP, DOWN, CLR} dir_t;

endpackage

// File: rtl/fan_speed_ctrl_dwell_filter.sv
// Consecutive-sample dwell filter: fires once DWELL valid samples in a row
// request the same direction.
module dwell_filter
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             valid_i,
    input  logic             flush_i,
    input  dir_t             dir_i,
    output logic             fire_c,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);

    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count/direction; a fire returns the filter to idle in the same edge.
    always_comb begin
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        fire_c = 1'b0;
        if (valid_i) begin
            if (flush_i || dir_i == NONE) begin
                dir_d = NONE;
                cnt_d = '0;
            end else begin
                dir_d = dir_i;
                if (dir_i == dir_q) begin
                    cnt_d = (cnt_q >= DWELL_C) ? DWELL_C : cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(1);
                end
                if (cnt_d == DWELL_C) begin
                    fire_c = 1'b1;
                    cnt_d  = '0;
                    dir_d  = NONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dir_q <= NONE;
            cnt_q <= '0;
        end else begin
            dir_q <= dir_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed FSM with threshold hysteresis, dwell filtering and a critical
// temperature override that forces HIGH and raises overheat.
module fan_speed_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned T_LOW_ON  = DEF_T_LOW_ON,
    parameter int unsigned T_MED_ON  = DEF_T_MED_ON,
    parameter int unsigned T_HIGH_ON = DEF_T_HIGH_ON,
    parameter int unsigned HYST      = DEF_HYST,
    parameter int unsigned T_CRIT    = DEF_T_CRIT,
    parameter int unsigned DWELL     = DEF_DWELL
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [TEMP_W-1:0] temperature,
    input  logic              temp_valid,
    output logic [1:0]        fan_speed,
    output logic              speed_chg,
    output logic              overheat,
    output logic [CNT_W-1:0]  dwell_cnt
);

    // Step-down thresholds are fixed at elaboration.
    localparam logic [TEMP_W-1:0] LOW_ON   = TEMP_W'(T_LOW_ON);
    localparam logic [TEMP_W-1:0] MED_ON   = TEMP_W'(T_MED_ON);
    localparam logic [TEMP_W-1:0] HIGH_ON  = TEMP_W'(T_HIGH_ON);
    localparam logic [TEMP_W-1:0] CRIT_ON  = TEMP_W'(T_CRIT);
    localparam logic [TEMP_W-1:0] LOW_OFF  = TEMP_W'(T_LOW_ON - HYST);
    localparam logic [TEMP_W-1:0] MED_OFF  = TEMP_W'(T_MED_ON - HYST);
    localparam logic [TEMP_W-1:0] HIGH_OFF = TEMP_W'(T_HIGH_ON - HYST);
    localparam logic [TEMP_W-1:0] CRIT_OFF = TEMP_W'(T_CRIT - HYST);

    fan_speed_t        speed_q, speed_d;
    logic              overheat_q, overheat_d;
    logic              speed_chg_q, speed_chg_d;
    logic [TEMP_W-1:0] up_thr_c, dn_thr_c;
    logic              has_up_c, has_dn_c;
    logic              crit_c;
    logic              fire_c;
    dir_t              dir_c;

    // Per-state thresholds; saturated ends have no direction in that sense.
    always_comb begin
        up_thr_c = LOW_ON;
        dn_thr_c = '0;
        has_up_c = 1'b1;
        has_dn_c = 1'b1;
        case (speed_q)
            OFF: begin
                up_thr_c = LOW_ON;
                has_dn_c = 1'b0;
            end
            LOW: begin
                up_thr_c = MED_ON;
                dn_thr_c = LOW_OFF;
            end
            MED: begin
                up_thr_c = HIGH_ON;
                dn_thr_c = MED_OFF;
            end
            HIGH: begin
                has_up_c = 1'b0;
                dn_thr_c = HIGH_OFF;
            end
        endcase
    end

    assign crit_c = (temperature >= CRIT_ON);

    // While overheated only the recovery direction can build up dwell.
    always_comb begin
        dir_c = NONE;
        if (overheat_q) begin
            if (temperature < CRIT_OFF) dir_c = CLR;
        end else if (has_up_c && temperature >= up_thr_c) begin
            dir_c = UP;
        end else if (has_dn_c && temperature < dn_thr_c) begin
            dir_c = DOWN;
        end
    end

    dwell_filter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk     (clk),
        .n_rst   (n_rst),
        .valid_i (temp_valid),
        .flush_i (crit_c),
        .dir_i   (dir_c),
        .fire_c  (fire_c),
        .count_o (dwell_cnt)
    );

    always_comb begin
        speed_d     = speed_q;
        overheat_d  = overheat_q;
        speed_chg_d = 1'b0;
        if (temp_valid) begin
            if (crit_c) begin
                speed_d    = HIGH;
                overheat_d = 1'b1;
            end else if (fire_c) begin
                case (dir_c)
                    UP:      speed_d = fan_speed_t'(speed_q + 2'd1);
                    DOWN:    speed_d = fan_speed_t'(speed_q - 2'd1);
                    CLR:     overheat_d = 1'b0;
                    default: ;
                endcase
            end
            speed_chg_d = (speed_d != speed_q);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            speed_q     <= OFF;
            overheat_q  <= 1'b0;
            speed_chg_q <= 1'b0;
        end else begin
            speed_q     <= speed_d;
            overheat_q  <= overheat_d;
            speed_chg_q <= speed_chg_d;
        end
    end

    assign fan_speed = speed_q;
    assign overheat  = overheat_q;
    assign speed_chg = speed_chg_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Scoreboard bench for fan_speed_ctrl: directed samples push hand-computed
// expectations, a monitor compares after every clock edge.
module tb_fan_speed_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [6:0] temperature;
    logic       temp_valid;
    logic [1:0] fan_speed;
    logic       speed_chg;
    logic       overheat;
    logic [3:0] dwell_cnt;

    typedef struct packed {
        logic [1:0] spd;
        logic       chg;
        logic       oh;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fan_speed_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .temperature (temperature),
        .temp_valid  (temp_valid),
        .fan_speed   (fan_speed),
        .speed_chg   (speed_chg),
        .overheat    (overheat),
        .dwell_cnt   (dwell_cnt)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // One valid sample and the outputs expected after the edge that takes it.
    task automatic send(input int t, input int s, input int c, input int o, input int d);
        exp_t e;
        @(negedge clk);
        temperature = 7'(t);
        temp_valid  = 1'b1;
        e.spd = 2'(s);
        e.chg = 1'(c);
        e.oh  = 1'(o);
        e.cnt = 4'(d);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        temp_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fan_speed"}, int'(fan_speed), 0);
        chk({tag, "_speed_chg"}, int'(speed_chg), 0);
        chk({tag, "_overheat"},  int'(overheat),  0);
        chk({tag, "_dwell_cnt"}, int'(dwell_cnt), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected responses never observed", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: valid edges pop an expectation, idle edges must hold state.
    initial begin : monitor
        logic seen;
        exp_t e;
        last = '0;
        forever begin
            @(posedge clk);
            seen = temp_valid;
            @(negedge clk);
            if (!n_rst) begin
                last = '0;
            end else if (seen) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_sample: no expectation queued at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("fan_speed", int'(fan_speed), int'(e.spd));
                    chk("speed_chg", int'(speed_chg), int'(e.chg));
                    chk("overheat",  int'(overheat),  int'(e.oh));
                    chk("dwell_cnt", int'(dwell_cnt), int'(e.cnt));
                    last     = e;
                    last.chg = 1'b0;
                end
            end else begin
                chk("hold_fan_speed", int'(fan_speed), int'(last.spd));
                chk("hold_speed_chg", int'(speed_chg), 0);
                chk("hold_overheat",  int'(overheat),  int'(last.oh));
                chk("hold_dwell_cnt", int'(dwell_cnt), int'(last.cnt));
            end
        end
    end

    initial begin : stimulus
        n_rst       = 1'b0;
        temp_valid  = 1'b0;
        temperature = '0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // OFF -> LOW after four samples at 45
        send(45, 0,0,0,1); send(45, 0,0,0,2); send(45, 0,0,0,3); send(45, 1,1,0,0);
        // LOW band holds; a lone 30 starts a down count that 45 cancels
        send(45, 1,0,0,0); send(45, 1,0,0,0); send(30, 1,0,0,1);
        for (int i = 0; i < 4; i++) send(45, 1,0,0,0);
        for (int i = 0; i < 4; i++) send(36, 1,0,0,0);
        send(34, 1,0,0,1); send(34, 1,0,0,2); send(34, 1,0,0,3); send(34, 0,1,0,0);
        idle(3);
        // no DOWN exists at OFF
        send(10, 0,0,0,0);
        // one level per fire while far above all thresholds
        send(95, 0,0,0,1); send(95, 0,0,0,2); send(95, 0,0,0,3); send(95, 1,1,0,0);
        send(95, 1,0,0,1); send(95, 1,0,0,2); send(95, 1,0,0,3); send(95, 2,1,0,0);
        send(95, 2,0,0,1); send(95, 2,0,0,2); send(95, 2,0,0,3); send(95, 3,1,0,0);
        send(95, 3,0,0,0);
        send(70, 3,0,0,1); send(70, 3,0,0,2); send(70, 3,0,0,3); send(70, 2,1,0,0);
        // critical from MED, recovery, then normal step-down
        send(100, 3,1,1,0);
        send(94, 3,0,1,1); send(94, 3,0,1,2); send(94, 3,0,1,3); send(94, 3,0,0,0);
        send(70, 3,0,0,1); send(70, 3,0,0,2); send(70, 3,0,0,3); send(70, 2,1,0,0);
        // critical again; repeat critical at HIGH gives no pulse; 96/97 are not recovery
        send(127, 3,1,1,0); send(110, 3,0,1,0); send(96, 3,0,1,0);
        send(94, 3,0,1,1); send(94, 3,0,1,2); send(97, 3,0,1,0);
        send(94, 3,0,1,1); send(94, 3,0,1,2); send(94, 3,0,1,3); send(94, 3,0,0,0);
        // critical sample flushes a pending down count
        send(70, 3,0,0,1); send(70, 3,0,0,2); send(105, 3,0,1,0);
        send(90, 3,0,1,1); send(90, 3,0,1,2); send(90, 3,0,1,3); send(90, 3,0,0,0);
        // idle gap between 2nd and 3rd qualifying samples keeps the count
        send(70, 3,0,0,1); send(70, 3,0,0,2);
        idle(10);
        send(70, 3,0,0,3); send(70, 2,1,0,0);
        // threshold edges at MED: 79/55 hold, 54 down, 80 up, 99 not critical
        send(79, 2,0,0,0); send(55, 2,0,0,0); send(54, 2,0,0,1);
        send(80, 2,0,0,1); send(99, 2,0,0,2);
        // asynchronous reset in the middle of an overheat recovery count
        send(100, 3,1,1,0); send(90, 3,0,1,1); send(90, 3,0,1,2);
        idle(1);
        drain();
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        send(50, 0,0,0,1); send(50, 0,0,0,2); send(50, 0,0,0,3); send(50, 1,1,0,0);
        idle(3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
